hazard_controller: RTL and testbench
====================================

# hazard_controller

Pipeline hazard and sequencing controller for the 5-stage CPU. It detects load-use hazards, flushes on taken branches, and schedules the multi-cycle mult/div unit, stalling decode while HI/LO or the unit is busy. It drives the PC, IF/ID and ID/EX control enables and sits alongside ForwardingUnit, covering the hazards forwarding cannot resolve. It also keeps a saturating stall-cycle performance counter.

## Interface
- MD_LATENCY, 32: mult/div occupancy in cycles (2..63).
- CNT_W, 6: mult/div down-counter width.
- clk  in  1  clock, rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- IDEX_MemRead  in  1  instruction in EX is a load.
- IDEX_Rt  in  5  destination register of that load.
- IFID_Rs  in  5  rs of the instruction in decode.
- IFID_Rt  in  5  rt of the instruction in decode.
- IFID_UsesRt  in  1  decode instruction reads rt.
- IFID_UsesMD  in  1  decode instruction is mult/div/mfhi/mflo.
- branch_taken  in  1  branch/jump resolved taken in EX.
- md_start  in  1  EX issues a mult/div this cycle.
- PCWrite  out  1  PC update enable.
- IFIDWrite  out  1  IF/ID register enable.
- IDEX_Bubble  out  1  load NOP control into ID/EX.
- IFID_Flush  out  1  clear IF/ID to NOP.
- md_busy  out  1  mult/div unit occupied.
- md_done  out  1  one-cycle pulse in the final busy cycle.
- stall_cycles  out  16  count of stall cycles, saturating.

## Operation
- FSM states are IDLE and MD_BUSY. The down-counter md_cnt is CNT_W bits wide.
- IDLE → MD_BUSY when md_start=1 and branch_taken=0. On that transition, md_cnt is loaded with MD_LATENCY-1.
- In MD_BUSY, md_cnt decrements each cycle. When md_cnt==0 the FSM returns to IDLE on the next edge. If md_start=1 on that same edge, it instead reloads and stays in MD_BUSY.
- md_busy = (state==MD_BUSY). md_done = md_busy && md_cnt==0.
- md_start is ignored in the same cycle as branch_taken.
- ld_haz = IDEX_MemRead && IDEX_Rt!=0 && (IDEX_Rt==IFID_Rs || (IFID_UsesRt && IDEX_Rt==IFID_Rt)).
- md_haz = md_busy && IFID_UsesMD. This includes the md_done cycle.
- stall = (ld_haz || md_haz) && !branch_taken.
- Output priority is fixed:
  - branch_taken=1: IFID_Flush=1, IDEX_Bubble=1, PCWrite=1, IFIDWrite=1. Any stall is cancelled because the decode instruction is killed.
  - else stall=1: PCWrite=0, IFIDWrite=0, IDEX_Bubble=1, IFID_Flush=0.
  - else: PCWrite=1, IFIDWrite=1, IDEX_Bubble=0, IFID_Flush=0.
- Simultaneous ld_haz and md_haz produce a single stall and count as one stall cycle.
- stall_cycles increments by 1 on each edge where stall=1. It holds at 0xFFFF and is cleared only by reset.
- A taken branch does not abort an in-flight mult/div. md_busy continues counting.

## Timing
- Control outputs are combinational from inputs and state, valid in the same cycle, with no added latency.
- md_busy rises on the edge after md_start and stays high exactly MD_LATENCY cycles. md_done is high in the last of those cycles.
- A load-use hazard produces exactly one stall cycle. The bubble clears IDEX_MemRead on the next cycle.
- While rst_n=0:
  - PCWrite=0, IFIDWrite=0, IDEX_Bubble=1, IFID_Flush=1.
  - state=IDLE, md_cnt=0, md_busy=0, md_done=0, stall_cycles=0.
- Asserting rst_n mid-operation aborts MD_BUSY immediately (asynchronous clear).
- After rst_n deasserts, the outputs follow the rules above from the next evaluation. There is no extra cycle.

## Test plan
- Load r5 in EX, decode instruction with rs=r5 → 1 cycle of PCWrite=0, IFIDWrite=0, IDEX_Bubble=1; stall_cycles goes 0→1. Same case with IDEX_Rt=0 → no stall.
- Load r7 in EX, decode rt=r7 with IFID_UsesRt=0 → no stall; with IFID_UsesRt=1 → 1-cycle stall.
- md_start pulse with MD_LATENCY=4 → md_busy high for cycles 1..4 and md_done in cycle 4. mfhi held in decode stalls cycles 1..4 (stall_cycles=4) and proceeds in cycle 5.
- branch_taken together with a load-use hazard → IFID_Flush=1, IDEX_Bubble=1, PCWrite=1, no stall_cycles increment. branch_taken together with md_start → md_busy stays 0.
- md_start on the md_done cycle → md_busy stays high for another MD_LATENCY cycles. rst_n pulsed low mid-busy → md_busy=0 and stall_cycles=0 immediately.
- Force continuous stall for 65540 cycles → stall_cycles saturates at 0xFFFF.

Source files
------------

// File: rtl/hazard_controller.sv
// Pipeline hazard controller: load-use stalls, branch flushes, mult/div occupancy
// scheduling and a saturating stall-cycle counter for the 5-stage CPU.
module hazard_controller #(
    parameter int unsigned MD_LATENCY = 32,
    parameter int unsigned CNT_W      = 6
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        IDEX_MemRead,
    input  logic [4:0]  IDEX_Rt,
    input  logic [4:0]  IFID_Rs,
    input  logic [4:0]  IFID_Rt,
    input  logic        IFID_UsesRt,
    input  logic        IFID_UsesMD,
    input  logic        branch_taken,
    input  logic        md_start,
    output logic        PCWrite,
    output logic        IFIDWrite,
    output logic        IDEX_Bubble,
    output logic        IFID_Flush,
    output logic        md_busy,
    output logic        md_done,
    output logic [15:0] stall_cycles
);

    localparam logic [0:0] IDLE    = 1'b0;
    localparam logic [0:0] MD_BUSY = 1'b1;

    logic [0:0]       state_q, state_d;
    logic [CNT_W-1:0] md_cnt_q, md_cnt_d;
    logic [15:0]      stall_cycles_q, stall_cycles_d;

    logic md_go;
    logic ld_haz;
    logic md_haz;
    logic stall;

    // A taken branch kills the issuing instruction, so its md_start is ignored.
    assign md_go = md_start && !branch_taken;

    assign md_busy = (state_q == MD_BUSY);
    assign md_done = md_busy && (md_cnt_q == '0);

    assign ld_haz = IDEX_MemRead && (IDEX_Rt != 5'd0) &&
                    ((IDEX_Rt == IFID_Rs) || (IFID_UsesRt && (IDEX_Rt == IFID_Rt)));
    assign md_haz = md_busy && IFID_UsesMD;
    assign stall  = (ld_haz || md_haz) && !branch_taken;

    assign stall_cycles = stall_cycles_q;

    always_comb begin
        state_d  = state_q;
        md_cnt_d = md_cnt_q;
        case (state_q)
            IDLE: begin
                if (md_go) begin
                    state_d  = MD_BUSY;
                    md_cnt_d = CNT_W'(MD_LATENCY - 1);
                end
            end
            MD_BUSY: begin
                if (md_cnt_q == '0) begin
                    // Back-to-back issue on the final busy cycle keeps the unit occupied.
                    if (md_go) begin
                        md_cnt_d = CNT_W'(MD_LATENCY - 1);
                    end else begin
                        state_d = IDLE;
                    end
                end else begin
                    md_cnt_d = md_cnt_q - 1'b1;
                end
            end
            default: begin
                state_d  = IDLE;
                md_cnt_d = '0;
            end
        endcase
    end

    always_comb begin
        stall_cycles_d = stall_cycles_q;
        if (stall && (stall_cycles_q != 16'hFFFF)) begin
            stall_cycles_d = stall_cycles_q + 16'd1;
        end
    end

    always_comb begin
        PCWrite     = 1'b1;
        IFIDWrite   = 1'b1;
        IDEX_Bubble = 1'b0;
        IFID_Flush  = 1'b0;
        if (!rst_n) begin
            PCWrite     = 1'b0;
            IFIDWrite   = 1'b0;
            IDEX_Bubble = 1'b1;
            IFID_Flush  = 1'b1;
        end else if (branch_taken) begin
            IDEX_Bubble = 1'b1;
            IFID_Flush  = 1'b1;
        end else if (stall) begin
            PCWrite     = 1'b0;
            IFIDWrite   = 1'b0;
            IDEX_Bubble = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= IDLE;
            md_cnt_q       <= '0;
            stall_cycles_q <= '0;
        end else begin
            state_q        <= state_d;
            md_cnt_q       <= md_cnt_d;
            stall_cycles_q <= stall_cycles_d;
        end
    end

endmodule

// File: tb/tb_hazard_controller.sv
// Directed bench for hazard_controller with MD_LATENCY=4; each step drives
// inputs just after a rising edge and checks hand-computed expectations.
module tb_hazard_controller;

    logic        clk;
    logic        rst_n;
    logic        IDEX_MemRead;
    logic [4:0]  IDEX_Rt;
    logic [4:0]  IFID_Rs;
    logic [4:0]  IFID_Rt;
    logic        IFID_UsesRt;
    logic        IFID_UsesMD;
    logic        branch_taken;
    logic        md_start;
    logic        PCWrite;
    logic        IFIDWrite;
    logic        IDEX_Bubble;
    logic        IFID_Flush;
    logic        md_busy;
    logic        md_done;
    logic [15:0] stall_cycles;

    int unsigned checks = 0;
    int unsigned errors = 0;

    hazard_controller #(
        .MD_LATENCY(4),
        .CNT_W(6)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .IDEX_MemRead(IDEX_MemRead),
        .IDEX_Rt(IDEX_Rt),
        .IFID_Rs(IFID_Rs),
        .IFID_Rt(IFID_Rt),
        .IFID_UsesRt(IFID_UsesRt),
        .IFID_UsesMD(IFID_UsesMD),
        .branch_taken(branch_taken),
        .md_start(md_start),
        .PCWrite(PCWrite),
        .IFIDWrite(IFIDWrite),
        .IDEX_Bubble(IDEX_Bubble),
        .IFID_Flush(IFID_Flush),
        .md_busy(md_busy),
        .md_done(md_done),
        .stall_cycles(stall_cycles)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #2;
    endtask

    // Control-output bundle {PCWrite, IFIDWrite, IDEX_Bubble, IFID_Flush}.
    function automatic logic [31:0] ctl();
        return {28'd0, PCWrite, IFIDWrite, IDEX_Bubble, IFID_Flush};
    endfunction

    task automatic clear_inputs();
        IDEX_MemRead = 1'b0;
        IDEX_Rt      = 5'd0;
        IFID_Rs      = 5'd0;
        IFID_Rt      = 5'd0;
        IFID_UsesRt  = 1'b0;
        IFID_UsesMD  = 1'b0;
        branch_taken = 1'b0;
        md_start     = 1'b0;
    endtask

    initial begin
        logic [15:0] exp_sc;

        rst_n = 1'b0;
        clear_inputs();
        #2;
        chk("reset_ctl", ctl(), 32'b0011);
        chk("reset_busy", {31'd0, md_busy}, 32'd0);
        chk("reset_done", {31'd0, md_done}, 32'd0);
        chk("reset_cnt", {16'd0, stall_cycles}, 32'd0);
        tick();
        rst_n = 1'b1;
        settle();
        chk("post_reset_ctl", ctl(), 32'b1100);

        // Load r5 / use rs=r5: one stall cycle, then the bubble clears the load.
        IDEX_MemRead = 1'b1; IDEX_Rt = 5'd5; IFID_Rs = 5'd5;
        settle();
        chk("ld_rs_stall_ctl", ctl(), 32'b0010);
        chk("ld_rs_cnt_before", {16'd0, stall_cycles}, 32'd0);
        tick();
        IDEX_MemRead = 1'b0;
        settle();
        chk("ld_rs_release_ctl", ctl(), 32'b1100);
        chk("ld_rs_cnt_after", {16'd0, stall_cycles}, 32'd1);

        // Load into r0 never stalls.
        IDEX_MemRead = 1'b1; IDEX_Rt = 5'd0; IFID_Rs = 5'd0; IFID_Rt = 5'd0; IFID_UsesRt = 1'b1;
        settle();
        chk("ld_r0_ctl", ctl(), 32'b1100);
        tick();
        settle();
        chk("ld_r0_cnt", {16'd0, stall_cycles}, 32'd1);

        // Load r7, decode rt=r7: stall only when rt is actually read.
        IDEX_Rt = 5'd7; IFID_Rs = 5'd1; IFID_Rt = 5'd7; IFID_UsesRt = 1'b0;
        settle();
        chk("ld_rt_unused_ctl", ctl(), 32'b1100);
        IFID_UsesRt = 1'b1;
        settle();
        chk("ld_rt_used_ctl", ctl(), 32'b0010);
        tick();
        clear_inputs();
        settle();
        chk("ld_rt_cnt", {16'd0, stall_cycles}, 32'd2);
        exp_sc = 16'd2;

        // mult/div issue with mfhi waiting in decode for the whole occupancy.
        md_start = 1'b1;
        settle();
        chk("md_issue_busy0", {31'd0, md_busy}, 32'd0);
        tick();
        md_start = 1'b0; IFID_UsesMD = 1'b1;
        for (int c = 1; c <= 4; c++) begin
            settle();
            chk($sformatf("md_busy_c%0d", c), {31'd0, md_busy}, 32'd1);
            chk($sformatf("md_done_c%0d", c), {31'd0, md_done}, (c == 4) ? 32'd1 : 32'd0);
            chk($sformatf("md_stall_c%0d", c), ctl(), 32'b0010);
            tick();
            exp_sc = exp_sc + 16'd1;
        end
        settle();
        chk("md_c5_busy", {31'd0, md_busy}, 32'd0);
        chk("md_c5_ctl", ctl(), 32'b1100);
        chk("md_stall_cnt", {16'd0, stall_cycles}, {16'd0, exp_sc});
        clear_inputs();

        // Taken branch overrides a load-use hazard and is not counted.
        IDEX_MemRead = 1'b1; IDEX_Rt = 5'd5; IFID_Rs = 5'd5; branch_taken = 1'b1;
        settle();
        chk("br_ld_ctl", ctl(), 32'b1111);
        tick();
        clear_inputs();
        settle();
        chk("br_ld_cnt", {16'd0, stall_cycles}, {16'd0, exp_sc});

        // Branch in the same cycle as md_start suppresses the issue.
        md_start = 1'b1; branch_taken = 1'b1;
        tick();
        clear_inputs();
        settle();
        chk("br_md_busy", {31'd0, md_busy}, 32'd0);

        // Reissue on the md_done cycle; a branch mid-busy does not abort.
        md_start = 1'b1;
        tick();
        md_start = 1'b0;
        for (int c = 1; c <= 8; c++) begin
            md_start     = (c == 4);
            branch_taken = (c == 6);
            settle();
            chk($sformatf("md2_busy_c%0d", c), {31'd0, md_busy}, 32'd1);
            chk($sformatf("md2_done_c%0d", c), {31'd0, md_done}, (c == 4 || c == 8) ? 32'd1 : 32'd0);
            tick();
        end
        clear_inputs();
        settle();
        chk("md2_end_busy", {31'd0, md_busy}, 32'd0);

        // Asynchronous reset mid-busy clears everything immediately.
        md_start = 1'b1;
        tick();
        md_start = 1'b0; IFID_UsesMD = 1'b1;
        tick();
        tick();
        rst_n = 1'b0;
        #1;
        chk("arst_busy", {31'd0, md_busy}, 32'd0);
        chk("arst_done", {31'd0, md_done}, 32'd0);
        chk("arst_cnt", {16'd0, stall_cycles}, 32'd0);
        chk("arst_ctl", ctl(), 32'b0011);
        tick();
        clear_inputs();
        rst_n = 1'b1;
        settle();
        chk("arst_release_ctl", ctl(), 32'b1100);

        // Continuous stall drives the counter into saturation.
        IDEX_MemRead = 1'b1; IDEX_Rt = 5'd5; IFID_Rs = 5'd5;
        repeat (65540) tick();
        settle();
        chk("sat_cnt", {16'd0, stall_cycles}, 32'h0000FFFF);
        chk("sat_ctl", ctl(), 32'b0010);
        clear_inputs();
        tick();
        settle();
        chk("sat_hold", {16'd0, stall_cycles}, 32'h0000FFFF);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
